// File: rtl/sfilt_mc.sv
// Multi-channel filter accumulator. Commands are load, multiply-accumulate, rounding
// shift-right and output-and-clear. Each command acts on one channel's accumulator.
module sfilt_mc #(
    parameter int DW  = 32,
    parameter int NCH = 4,
    parameter int SHW = 7,
    parameter int SAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pushin,
    input  logic [1:0]                cmd,
    input  logic [$clog2(NCH)-1:0]    ch,
    input  logic signed [DW-1:0]      q,
    input  logic signed [DW-1:0]      h,
    output logic                      pushout,
    output logic [$clog2(NCH)-1:0]    chout,
    output logic signed [DW-1:0]      z,
    output logic                      ovf
);

    localparam int ACCW = 2 * DW;
    localparam int CW   = $clog2(NCH);
    localparam int SW   = $clog2(ACCW);

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_MAC  = 2'd1,
        CMD_SHR  = 2'd2,
        CMD_OUT  = 2'd3
    } cmd_e;

    logic                   r_s1Valid;
    cmd_e                   r_s1Cmd;
    logic [CW-1:0]          r_s1Ch;
    logic signed [DW-1:0]   r_s1Q;
    logic signed [DW-1:0]   r_s1H;

    logic                   r_s2Valid;
    cmd_e                   r_s2Cmd;
    logic [CW-1:0]          r_s2Ch;
    logic signed [ACCW-1:0] r_s2Prod;
    logic [SHW-1:0]         r_s2Shift;

    logic signed [ACCW-1:0] r_acc [NCH];

    logic                   r_s3Valid;
    logic [CW-1:0]          r_s3Ch;
    logic [DW-1:0]          r_s3Z;
    logic                   r_s3Ovf;

    logic                   r_pushout;
    logic [CW-1:0]          r_chout;
    logic [DW-1:0]          r_z;
    logic                   r_ovf;

    logic signed [ACCW-1:0] w_qExt;
    logic signed [ACCW-1:0] w_hExt;
    logic signed [ACCW-1:0] w_prod;

    logic signed [ACCW-1:0] w_accCur;
    logic [SW-1:0]          w_shAmt;
    logic                   w_rndBit;
    logic signed [ACCW-1:0] w_asr;
    logic signed [ACCW-1:0] w_shifted;
    logic [ACCW-DW:0]       w_hi;
    logic                   w_ovf;
    logic [DW-1:0]          w_z;
    logic signed [ACCW-1:0] w_accNext;

    assign w_qExt = {{DW{r_s1Q[DW-1]}}, r_s1Q};
    assign w_hExt = {{DW{r_s1H[DW-1]}}, r_s1H};
    assign w_prod = w_qExt * w_hExt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Cmd   <= CMD_LOAD;
            r_s1Ch    <= '0;
            r_s1Q     <= '0;
            r_s1H     <= '0;
            r_s2Valid <= 1'b0;
            r_s2Cmd   <= CMD_LOAD;
            r_s2Ch    <= '0;
            r_s2Prod  <= '0;
            r_s2Shift <= '0;
        end else begin
            r_s1Valid <= pushin;
            r_s1Cmd   <= cmd_e'(cmd);
            r_s1Ch    <= ch;
            r_s1Q     <= q;
            r_s1H     <= h;
            r_s2Valid <= r_s1Valid;
            r_s2Cmd   <= r_s1Cmd;
            r_s2Ch    <= r_s1Ch;
            r_s2Prod  <= w_prod;
            r_s2Shift <= r_s1H[SHW-1:0];
        end
    end

    // Accumulator is read and written only here, so same-channel commands chain naturally
    always_comb begin
        w_accCur  = r_acc[r_s2Ch];
        w_shAmt   = (int'(r_s2Shift) >= ACCW) ? SW'(ACCW - 1) : SW'(r_s2Shift);
        w_rndBit  = (w_shAmt == '0) ? 1'b0 : w_accCur[w_shAmt - SW'(1)];
        w_asr     = w_accCur >>> w_shAmt;
        w_shifted = w_asr + $signed({{(ACCW-1){1'b0}}, w_rndBit});
        w_hi      = w_accCur[ACCW-1:DW-1];
        w_ovf     = !((&w_hi) || !(|w_hi));
        w_z       = w_accCur[DW-1:0];
        if ((SAT != 0) && w_ovf) begin
            w_z = w_accCur[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        w_accNext = w_accCur;
        case (r_s2Cmd)
            CMD_LOAD: w_accNext = r_s2Prod;
            CMD_MAC:  w_accNext = w_accCur + r_s2Prod;
            CMD_SHR:  w_accNext = w_shifted;
            CMD_OUT:  w_accNext = '0;
            default:  w_accNext = w_accCur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
            r_s3Valid <= 1'b0;
            r_s3Ch    <= '0;
            r_s3Z     <= '0;
            r_s3Ovf   <= 1'b0;
            r_pushout <= 1'b0;
            r_chout   <= '0;
            r_z       <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (r_s2Valid) begin
                r_acc[r_s2Ch] <= w_accNext;
            end
            r_s3Valid <= r_s2Valid && (r_s2Cmd == CMD_OUT);
            if (r_s2Valid && (r_s2Cmd == CMD_OUT)) begin
                r_s3Ch  <= r_s2Ch;
                r_s3Z   <= w_z;
                r_s3Ovf <= w_ovf;
            end
            // Result registers hold until the next output command reaches them
            r_pushout <= r_s3Valid;
            if (r_s3Valid) begin
                r_chout <= r_s3Ch;
                r_z     <= r_s3Z;
                r_ovf   <= r_s3Ovf;
            end
        end
    end

    assign pushout = r_pushout;
    assign chout   = r_chout;
    assign z       = r_z;
    assign ovf     = r_ovf;

endmodule

// File: doc/sfilt_mc.md
SFILT_MC -- requirements
Module: sfilt_mc

Interface
REQ-001 Parameter DW, default 32, width of the q, h and z data paths.
REQ-002 Parameter NCH, default 4, number of independent accumulator channels, power of two, at least 2.
REQ-003 Parameter SHW, default 7, width of the cmd2 shift amount taken from h[SHW-1:0].
REQ-004 Parameter SAT, default 1: 1 = saturate on output, 0 = truncate on output.
REQ-005 Derived ACCW = 2*DW, accumulator width; CW = log2(NCH), channel select width.
REQ-006 clk  input  1  clock, all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 pushin  input  1  command valid; q, h, cmd and ch are sampled when high.
REQ-009 cmd  input  2  command: 0 = load product, 1 = multiply-accumulate, 2 = shift-right-round, 3 = output and clear.
REQ-010 ch  input  CW  target channel of the command.
REQ-011 q  input  DW  signed data operand.
REQ-012 h  input  DW  signed coefficient; for cmd2, bits [SHW-1:0] are an unsigned shift amount.
REQ-013 pushout  output  1  one-cycle strobe marking valid z, chout and ovf.
REQ-014 chout  output  CW  channel that produced z.
REQ-015 z  output  DW  signed result.
REQ-016 ovf  output  1  accumulator exceeded the DW signed range at output time.

Function
REQ-017 Pipeline SHALL have 3 stages:
- S1 registers pushin, cmd, ch, q and h.
- S2 registers the full-precision signed product q*h (ACCW bits) plus the propagated controls.
- S3 reads and writes acc[ch].
REQ-018 Block SHALL accept one command per cycle with no stall, and commands SHALL take effect in issue order.
REQ-019 Back-to-back commands to the same channel SHALL see the previous result, because acc is read and written only in S3; no stall and no bubble are permitted.
REQ-020 cmd0 SHALL set acc[ch] = product.
REQ-021 cmd1 SHALL set acc[ch] = acc[ch] + product, wrapping modulo 2^ACCW.
REQ-022 cmd2 with shift amount s SHALL set acc[ch] = (acc[ch] >>> s) + acc[ch][s-1]:
- rounding is half-up toward +inf;
- s = 0 leaves acc unchanged;
- s >= ACCW is clamped to ACCW-1.
REQ-023 cmd3 SHALL set z from acc[ch] and clear acc[ch] to 0:
- SAT = 1: z = acc clamped to [-2^(DW-1), 2^(DW-1)-1];
- SAT = 0: z = acc[DW-1:0].
REQ-024 cmd3 SHALL also set chout = ch and pulse pushout for exactly one cycle.
REQ-025 ovf SHALL equal 1 with pushout when acc[ch] lies outside the DW signed range (same test for either SAT value), else 0.
REQ-026 Latency: pushout SHALL assert on the 3rd rising edge after the edge sampling a cmd3 pushin.
REQ-027 z, chout and ovf SHALL hold their values until the next cmd3 completes.
REQ-028 Channels SHALL be fully independent; a command on channel a SHALL never alter acc[b].
REQ-029 Cycles with pushin low SHALL leave every accumulator unchanged.
REQ-030 Consecutive cmd3 commands SHALL give consecutive pushout pulses; cmd3 on an already-cleared channel SHALL output z = 0.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL clear all pipeline valids and all acc[] to 0.
REQ-032 Reset SHALL drive pushout = 0, z = 0, chout = 0 and ovf = 0.
REQ-033 Commands in flight when rst asserts SHALL be discarded and SHALL produce no pushout.
REQ-034 pushin sampled in the same cycle as rst high SHALL be ignored.
REQ-035 The first command accepted after rst deasserts SHALL behave as on a fresh accumulator.

Verification
REQ-036 Single channel: ch0 cmd0 q=3,h=4; cmd1 q=-2,h=5; cmd3 -> z=2, ovf=0, pushout exactly 3 cycles after cmd3.
REQ-037 Shift and round: ch1 cmd0 q=7,h=1; cmd2 h=1; cmd3 -> z=4 (3.5 rounds up); repeat with q=-7 -> z=-3; cmd2 with s=0 -> value unchanged.
REQ-038 Interleaved channels, back-to-back, no gaps: ch0 cmd0 2*3, ch1 cmd0 5*5, ch0 cmd1 1*1, ch1 cmd3, ch0 cmd3 -> z=25 chout=1, then next cycle z=7 chout=0.
REQ-039 Saturation (SAT=1, DW=32): cmd0 q=h=0x7FFFFFFF; cmd3 -> z=0x7FFFFFFF, ovf=1; SAT=0 build -> z=0x00000001, ovf=1.
REQ-040 Reset mid-flight: issue cmd3 on ch2 after loading 9, assert rst the next cycle -> no pushout, then cmd3 on ch2 -> z=0.
REQ-041 Clamp: acc=-1, cmd2 h[6:0]=127 -> acc=-1 (shift by 63, round bit 1 adds back to 0? check: -1>>>63 = -1, bit62 = 1 -> 0); expected z=0.
